// File: rtl/cpu_memwb_stage_if.sv
// MEM-to-WB bundle for the 5-stage CPU.
// The MEM stage drives it (master); the MEM/WB register receives it (slave).
interface cpu_memwb_stage_if #(
    parameter int DW = 16,
    parameter int RW = 4
);
    logic          mem_valid;
    logic [DW-1:0] mem_aluOut;
    logic [DW-1:0] mem_dataOut;
    logic [DW-1:0] mem_pcPlus2;
    logic          mem_regWrite;
    logic [1:0]    mem_wbSel;
    logic [RW-1:0] mem_rd;
    logic          mem_halt;

    modport master (
        output mem_valid,
        output mem_aluOut,
        output mem_dataOut,
        output mem_pcPlus2,
        output mem_regWrite,
        output mem_wbSel,
        output mem_rd,
        output mem_halt
    );

    modport slave (
        input mem_valid,
        input mem_aluOut,
        input mem_dataOut,
        input mem_pcPlus2,
        input mem_regWrite,
        input mem_wbSel,
        input mem_rd,
        input mem_halt
    );
endinterface

// File: rtl/cpu_memwb_stage.sv
// MEM/WB pipeline register, writeback select and HLT retirement tracking.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module cpu_memwb_stage #(
    parameter int DW = 16,
    parameter int RW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    cpu_memwb_stage_if.slave     mem,
    output logic                 WB_valid,
    output logic                 WB_regWrite,
    output logic [RW-1:0]        WB_rd,
    output logic [DW-1:0]        WB_fdata,
    output logic                 halted,
    output logic [15:0]          retire_count
);

    typedef struct packed {
        logic          valid;
        logic          regWrite;
        logic [1:0]    wbSel;
        logic [RW-1:0] rd;
        logic          halt;
        logic [DW-1:0] aluOut;
        logic [DW-1:0] dataOut;
        logic [DW-1:0] pcPlus2;
    } stage_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    stage_t stageQ;
    stage_t stageD;
    state_t stateQ;
    state_t stateD;

    logic retire;
    logic haltRetire;

    // The WB instruction leaves the stage; HLT leaving ends execution
    always_comb begin
        retire     = stageQ.valid & ~stall;
        haltRetire = retire & stageQ.halt & (stateQ == RUN);
    end

    // Next stage contents: halt/flush bubble, stall hold, or capture
    always_comb begin
        stageD = stageQ;
        if ((stateQ == HALTED) || haltRetire || flush) begin
            stageD.valid    = 1'b0;
            stageD.regWrite = 1'b0;
            stageD.halt     = 1'b0;
        end else if (!stall) begin
            stageD.valid    = mem.mem_valid;
            stageD.regWrite = mem.mem_regWrite;
            stageD.wbSel    = mem.mem_wbSel;
            stageD.rd       = mem.mem_rd;
            stageD.halt     = mem.mem_halt;
            stageD.aluOut   = mem.mem_aluOut;
            stageD.dataOut  = mem.mem_dataOut;
            stageD.pcPlus2  = mem.mem_pcPlus2;
        end
    end

    // Stage register
    always_ff @(posedge clk) begin
        if (rst) begin
            stageQ <= '0;
        end else begin
            stageQ <= stageD;
        end
    end

    // Halt FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= RUN;
        end else begin
            stateQ <= stateD;
        end
    end

    // Halt FSM next state; only reset leaves HALTED
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            RUN: begin
                if (haltRetire) begin
                    stateD = HALTED;
                end
            end
            HALTED: begin
                stateD = HALTED;
            end
            default: begin
                stateD = RUN;
            end
        endcase
    end

    // Halt FSM outputs
    always_comb begin
        halted = (stateQ == HALTED);
    end

    // Register-file write port; R0 writes are never issued
    always_comb begin
        WB_valid    = stageQ.valid;
        WB_regWrite = stageQ.valid & stageQ.regWrite & (|stageQ.rd);
        WB_rd       = stageQ.rd;
    end

    // Writeback source select, also feeds MEM-stage forwarding
    always_comb begin
        WB_fdata = stageQ.aluOut;
        unique case (stageQ.wbSel)
            2'b00:   WB_fdata = stageQ.aluOut;
            2'b01:   WB_fdata = stageQ.dataOut;
            2'b10:   WB_fdata = stageQ.pcPlus2;
            default: WB_fdata = stageQ.aluOut;
        endcase
    end

`ifdef WB_RETIRE_CNT_EN
    logic [15:0] retireCnt;

    // Count retiring instructions until the CPU halts
    always_ff @(posedge clk) begin
        if (rst) begin
            retireCnt <= 16'h0000;
        end else if (retire && (stateQ == RUN)) begin
            retireCnt <= retireCnt + 16'd1;
        end
    end

    assign retire_count = retireCnt;
`else
    assign retire_count = 16'h0000;
`endif

endmodule
